layer_sequencer: RTL
====================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter MAX_LAYERS, 16, table depth, max layers per run.
REQ-002 Parameter LAYER_W, 4, layer index width; 2^LAYER_W SHALL be >= MAX_LAYERS.
REQ-003 Parameter TIMEOUT_W, 20, per-layer watchdog counter width.
REQ-004 Ports (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ena  in  1  synchronous enable; 0 = all state, counters and outputs hold
- cfgWe  in  1  layer-table write strobe
- cfgAddr  in  LAYER_W  table entry index
- cfgType  in  2  00 conv, 01 pool, 10 fc, 11 end-of-list
- numLayers  in  LAYER_W+1  layer count, sampled on start
- pcieDataReady  in  1  level; input data loaded, start request
- convStatus / poolStatus / fcStatus  in  1 each  one-cycle engine-done pulses
- abort  in  1  synchronous abort
- runLayer  out  LAYER_W  current layer index
- runType  out  2  current layer type
- runValid  out  1  high while a layer is running
- convRst / poolRst / fcRst  out  1 each  active-low engine reset pulses
- weightReadEn / biasReadEn  out  1 each  parameter fetch enables
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- timeoutErr  out  1  sticky watchdog error

Function
REQ-005 FSM states: IDLE, LAUNCH, RUN, DONE, ERR.
REQ-006 Table writes SHALL take effect only in IDLE; writes in other states SHALL be dropped; cfgAddr >= MAX_LAYERS dropped.
REQ-007 IDLE: on pcieDataReady=1, latch N = min(numLayers, MAX_LAYERS); N=0 -> DONE; else runLayer=0, -> LAUNCH.
REQ-008 LAUNCH (exactly 1 cycle): runType = table[runLayer]; the matching engine reset SHALL be low this cycle only; watchdog cleared; -> RUN.
REQ-009 LAUNCH with table entry 11: no engine reset pulse, -> DONE.
REQ-010 RUN: runValid=1; weightReadEn=biasReadEn=1 when runType is conv or fc, 0 for pool.
REQ-011 RUN: only the status pulse matching runType SHALL advance; non-matching pulses ignored; status pulses outside RUN ignored.
REQ-012 On matching status: runLayer=N-1 -> DONE; else runLayer+1, -> LAUNCH (next launch 1 cycle after status).
REQ-013 Watchdog increments each enabled RUN cycle; reaching all-ones -> timeoutErr=1, -> ERR; matching status in the same cycle wins over expiry.
REQ-014 DONE: done=1 for one cycle, then remain in DONE until pcieDataReady=0, then -> IDLE (no re-trigger on held level).
REQ-015 ERR: busy=1, runValid=0, holds until abort; timeoutErr cleared only by abort or reset.
REQ-016 abort=1 in any state -> IDLE next cycle, runValid=0, engine resets high, timeoutErr cleared, table retained; abort has priority over all other events.
REQ-017 busy=1 in LAUNCH, RUN, ERR; 0 in IDLE and DONE.
REQ-018 All outputs SHALL be registered; ena=0 freezes pulses (a pulse in progress extends until ena returns).

Reset
REQ-019 rst=0 SHALL asynchronously force: state IDLE, runLayer=0, runType=00, runValid=0, convRst=poolRst=fcRst=1, weightReadEn=biasReadEn=0, busy=0, done=0, timeoutErr=0, watchdog=0, all table entries=11.
REQ-020 Reset asserted mid-sequence SHALL abandon the run with the same values; deassertion SHALL be followed by IDLE operation on the next rising edge.

Verification
REQ-021 Table = AlexNet 11 entries (C,P,C,P,C,C,C,P,F,F,F), numLayers=11, pcieDataReady=1, matching status 3 cycles after each launch -> 11 launches, correct engine reset per layer, done pulse after layer 10, runLayer sequence 0..10.
REQ-022 Unprogrammed table after reset, numLayers=5, start -> no engine reset pulse, done within 3 cycles.
REQ-023 Layer 0 conv, inject poolStatus and fcStatus during RUN -> runLayer stays 0; convStatus then advances.
REQ-024 TIMEOUT_W=4, no status -> timeoutErr=1 after 15 RUN cycles, state ERR; abort -> IDLE, timeoutErr=0, table intact (rerun succeeds).
REQ-025 numLayers=20 with MAX_LAYERS=16 -> exactly 16 launches; cfgWe during RUN -> table unchanged.
REQ-026 rst low during RUN of layer 3 -> all outputs at reset values immediately; pcieDataReady held high after release -> new run starts at layer 0 with all entries 11 (immediate done).

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a programmable table of conv/pool/fc layers, pulsing the matching
// engine reset per layer, waiting for its done pulse, and guarding each layer with a watchdog.
module layer_sequencer #(
    parameter int unsigned MAX_LAYERS = 16,
    parameter int unsigned LAYER_W    = 4,
    parameter int unsigned TIMEOUT_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               cfgWe,
    input  logic [LAYER_W-1:0] cfgAddr,
    input  logic [1:0]         cfgType,
    input  logic [LAYER_W:0]   numLayers,
    input  logic               pcieDataReady,
    input  logic               convStatus,
    input  logic               poolStatus,
    input  logic               fcStatus,
    input  logic               abort,
    output logic [LAYER_W-1:0] runLayer,
    output logic [1:0]         runType,
    output logic               runValid,
    output logic               convRst,
    output logic               poolRst,
    output logic               fcRst,
    output logic               weightReadEn,
    output logic               biasReadEn,
    output logic               busy,
    output logic               done,
    output logic               timeoutErr
);

    localparam int unsigned NW = LAYER_W + 1;
    localparam logic [1:0] T_CONV = 2'b00;
    localparam logic [1:0] T_POOL = 2'b01;
    localparam logic [1:0] T_FC   = 2'b10;
    localparam logic [1:0] T_END  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE, S_ERR} state_t;

    state_t               state_q, state_d;
    logic [LAYER_W-1:0]   run_layer_q, run_layer_d;
    logic [1:0]           run_type_q, run_type_d;
    logic [NW-1:0]        n_q, n_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout_q, timeout_d;
    logic [1:0]           table_q [MAX_LAYERS];
    logic [1:0]           table_d [MAX_LAYERS];
    logic                 run_valid_q, run_valid_d;
    logic                 conv_rst_q, conv_rst_d;
    logic                 pool_rst_q, pool_rst_d;
    logic                 fc_rst_q, fc_rst_d;
    logic                 param_rd_q, param_rd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [TIMEOUT_W-1:0] wd_inc;
    logic [LAYER_W-1:0]   next_layer;
    logic                 status_match;

    assign wd_inc     = wd_q + TIMEOUT_W'(1);
    assign next_layer = run_layer_q + LAYER_W'(1);
    assign status_match = (run_type_q == T_CONV && convStatus) ||
                          (run_type_q == T_POOL && poolStatus) ||
                          (run_type_q == T_FC   && fcStatus);

    // State and registered outputs; ena gating is folded into the _d logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            run_layer_q <= '0;
            run_type_q  <= T_CONV;
            n_q         <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < int'(MAX_LAYERS); i++) table_q[i] <= T_END;
            run_valid_q <= 1'b0;
            conv_rst_q  <= 1'b1;
            pool_rst_q  <= 1'b1;
            fc_rst_q    <= 1'b1;
            param_rd_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_layer_q <= run_layer_d;
            run_type_q  <= run_type_d;
            n_q         <= n_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            table_q     <= table_d;
            run_valid_q <= run_valid_d;
            conv_rst_q  <= conv_rst_d;
            pool_rst_q  <= pool_rst_d;
            fc_rst_q    <= fc_rst_d;
            param_rd_q  <= param_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: abort beats everything; a matching status beats watchdog expiry
    always_comb begin
        state_d     = state_q;
        run_layer_d = run_layer_q;
        run_type_d  = run_type_q;
        n_d         = n_q;
        wd_d        = wd_q;
        timeout_d   = timeout_q;
        table_d     = table_q;
        if (ena) begin
            if (abort) begin
                state_d     = S_IDLE;
                timeout_d   = 1'b0;
                run_layer_d = '0;
                run_type_d  = T_CONV;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cfgWe && ({1'b0, cfgAddr} < NW'(MAX_LAYERS)))
                            table_d[cfgAddr] = cfgType;
                        if (pcieDataReady) begin
                            n_d = (numLayers > NW'(MAX_LAYERS)) ? NW'(MAX_LAYERS) : numLayers;
                            if (n_d == '0) begin
                                state_d = S_DONE;
                            end else begin
                                run_layer_d = '0;
                                run_type_d  = table_q[0];
                                state_d     = S_LAUNCH;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        wd_d    = '0;
                        state_d = (run_type_q == T_END) ? S_DONE : S_RUN;
                    end
                    S_RUN: begin
                        if (status_match) begin
                            if (NW'(run_layer_q) + NW'(1) == n_q) begin
                                state_d = S_DONE;
                            end else begin
                                run_layer_d = next_layer;
                                run_type_d  = table_q[next_layer];
                                state_d     = S_LAUNCH;
                            end
                        end else begin
                            wd_d = wd_inc;
                            if (wd_inc == {TIMEOUT_W{1'b1}}) begin
                                state_d   = S_ERR;
                                timeout_d = 1'b1;
                            end
                        end
                    end
                    S_DONE: if (!pcieDataReady) state_d = S_IDLE;
                    S_ERR:  state_d = S_ERR;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Output decode from the upcoming state so every output comes straight off a flop
    always_comb begin
        run_valid_d = run_valid_q;
        conv_rst_d  = conv_rst_q;
        pool_rst_d  = pool_rst_q;
        fc_rst_d    = fc_rst_q;
        param_rd_d  = param_rd_q;
        busy_d      = busy_q;
        done_d      = done_q;
        if (ena) begin
            busy_d      = state_d inside {S_LAUNCH, S_RUN, S_ERR};
            run_valid_d = (state_d == S_RUN);
            conv_rst_d  = !(state_d == S_LAUNCH && run_type_d == T_CONV);
            pool_rst_d  = !(state_d == S_LAUNCH && run_type_d == T_POOL);
            fc_rst_d    = !(state_d == S_LAUNCH && run_type_d == T_FC);
            param_rd_d  = (state_d == S_RUN) && (run_type_d == T_CONV || run_type_d == T_FC);
            done_d      = (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    assign runLayer     = run_layer_q;
    assign runType      = run_type_q;
    assign runValid     = run_valid_q;
    assign convRst      = conv_rst_q;
    assign poolRst      = pool_rst_q;
    assign fcRst        = fc_rst_q;
    assign weightReadEn = param_rd_q;
    assign biasReadEn   = param_rd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeoutErr   = timeout_q;

endmodule
